// File: rtl/bcd_score_keeper.sv
// Decimal score keeper: award FIFO, digit-serial saturating BCD adder, high-score register
// and active-low seven-segment display of either score.
module bcd_score_keeper #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned PTS_DIGITS = 2,
  parameter int unsigned QDEPTH     = 4,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    award_valid,
  input  logic [4*PTS_DIGITS-1:0] award_pts,
  output logic                    award_ready,
  input  logic                    new_game,
  input  logic                    game_over,
  input  logic                    show_high,
  output logic [4*DIGITS-1:0]     score_bcd,
  output logic [4*DIGITS-1:0]     high_bcd,
  output logic                    busy,
  output logic                    saturated,
  output logic                    dropped,
  output logic [7*DIGITS-1:0]     hex
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LastIdx = IW'(DIGITS - 1);
  localparam logic [4*DIGITS-1:0] AllNines = {DIGITS{4'h9}};

  typedef enum logic [1:0] {StIdle, StAdd, StHiscore} state_e;

  state_e                  state;
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           wr_ptr;
  logic [CW-1:0]           count;
  logic [4*PTS_DIGITS-1:0] fifo_mem [QDEPTH];
  logic [4*DIGITS-1:0]     op;
  logic [4*DIGITS-1:0]     work;
  logic [IW-1:0]           idx;
  logic                    carry;
  logic                    go_pending;

  logic [4*PTS_DIGITS-1:0] pts_clamped;
  logic                    push;
  logic                    pop;
  logic [4:0]              add_sum;
  logic                    add_carry;
  logic [3:0]              add_digit;
  logic [4*DIGITS-1:0]     work_next;
  logic [4*DIGITS-1:0]     disp;
  logic                    zero_above;

  assign award_ready = (count < CW'(QDEPTH));
  assign push        = award_valid && award_ready && !new_game && !reset;
  assign pop         = (state == StIdle) && (count != '0);
  assign busy        = (state != StIdle) || (count != '0) || go_pending;

  always_comb begin
    pts_clamped = award_pts;
    for (int i = 0; i < int'(PTS_DIGITS); i++) begin
      if (award_pts[4*i +: 4] > 4'd9) pts_clamped[4*i +: 4] = 4'd9;
    end
  end

  // One decimal digit of score + operand + carry per ADD cycle.
  always_comb begin
    add_sum   = 5'(score_bcd[4*idx +: 4]) + 5'(op[4*idx +: 4]) + 5'(carry);
    add_carry = (add_sum > 5'd9);
    add_digit = add_carry ? 4'(add_sum - 5'd10) : add_sum[3:0];
    work_next = work;
    work_next[4*idx +: 4] = add_digit;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pts_clamped;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      op         <= '0;
      work       <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      go_pending <= 1'b0;
      score_bcd  <= '0;
      high_bcd   <= '0;
      saturated  <= 1'b0;
      dropped    <= 1'b0;
    end else if (new_game) begin
      // Abort everything in flight; the high score survives.
      state      <= StIdle;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      go_pending <= 1'b0;
      score_bcd  <= '0;
      saturated  <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      if (award_valid && !award_ready) dropped <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (game_over) go_pending <= 1'b1;

      case (state)
        StIdle: begin
          if (pop) begin
            op     <= (4*DIGITS)'(fifo_mem[rd_ptr]);
            rd_ptr <= rd_ptr + 1'b1;
            idx    <= '0;
            carry  <= 1'b0;
            work   <= '0;
            state  <= StAdd;
          end else if (go_pending) begin
            state <= StHiscore;
          end
        end
        StAdd: begin
          work  <= work_next;
          carry <= add_carry;
          if (idx == LastIdx) begin
            if (add_carry) begin
              score_bcd <= AllNines;
              saturated <= 1'b1;
            end else begin
              score_bcd <= work_next;
            end
            state <= StIdle;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        StHiscore: begin
          // Valid BCD orders the same as its binary encoding.
          if (score_bcd > high_bcd) high_bcd <= score_bcd;
          go_pending <= 1'b0;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    disp       = show_high ? high_bcd : score_bcd;
    hex        = '1;
    zero_above = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      zero_above = zero_above & (disp[4*k +: 4] == 4'd0);
      if (BLANK_LZ && (k != 0) && zero_above) hex[7*k +: 7] = 7'h7F;
      else                                    hex[7*k +: 7] = seg7(disp[4*k +: 4]);
    end
  end

endmodule

// File: tb/tb_bcd_score_keeper.sv
// Self-checking bench: integer-arithmetic reference model compared every cycle, plus
// directed scenarios with literal expectations and a randomized soak.
module tb_bcd_score_keeper;

  localparam int unsigned DIGITS     = 4;
  localparam int unsigned PTS_DIGITS = 2;
  localparam int unsigned QDEPTH     = 4;
  localparam bit          BLANK_LZ   = 1'b1;
  localparam int          MAXV       = 9999;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    award_valid;
  logic [4*PTS_DIGITS-1:0] award_pts;
  logic                    award_ready;
  logic                    new_game;
  logic                    game_over;
  logic                    show_high;
  logic [4*DIGITS-1:0]     score_bcd;
  logic [4*DIGITS-1:0]     high_bcd;
  logic                    busy;
  logic                    saturated;
  logic                    dropped;
  logic [7*DIGITS-1:0]     hex;

  bcd_score_keeper #(
    .DIGITS    (DIGITS),
    .PTS_DIGITS(PTS_DIGITS),
    .QDEPTH    (QDEPTH),
    .BLANK_LZ  (BLANK_LZ)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .award_valid(award_valid),
    .award_pts  (award_pts),
    .award_ready(award_ready),
    .new_game   (new_game),
    .game_over  (game_over),
    .show_high  (show_high),
    .score_bcd  (score_bcd),
    .high_bcd   (high_bcd),
    .busy       (busy),
    .saturated  (saturated),
    .dropped    (dropped),
    .hex        (hex)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: the score is a plain integer, the FIFO a queue, the adder a countdown.
  int q[$];
  int m_score = 0, m_high = 0, m_op = 0, m_rem = 0, m_mode = 0;
  bit m_pend = 0, m_sat = 0, m_drop = 0;
  int old_n, old_mode;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int clamp_pts(input logic [4*PTS_DIGITS-1:0] p);
    int v = 0, w = 1, d;
    for (int k = 0; k < int'(PTS_DIGITS); k++) begin
      d = int'(p[4*k +: 4]);
      if (d > 9) d = 9;
      v += d * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r = '0;
    int p = 1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [7*DIGITS-1:0] model_hex(input int v);
    logic [7*DIGITS-1:0] r = '0;
    int p = 1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (BLANK_LZ && k > 0 && v < p) r[7*k +: 7] = 7'h7F;
      else                             r[7*k +: 7] = seg_tab[(v / p) % 10];
      p *= 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_score = 0; m_high = 0; m_mode = 0; m_rem = 0;
      m_pend = 0; m_sat = 0; m_drop = 0;
    end else if (new_game) begin
      q.delete();
      m_score = 0; m_mode = 0; m_rem = 0;
      m_pend = 0; m_sat = 0; m_drop = 0;
    end else begin
      old_n    = q.size();
      old_mode = m_mode;
      case (old_mode)
        0: begin
          if (old_n > 0) begin
            m_op = q.pop_front(); m_rem = DIGITS; m_mode = 1;
          end else if (m_pend) begin
            m_mode = 2;
          end
        end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            if (m_score + m_op > MAXV) begin m_score = MAXV; m_sat = 1; end
            else m_score = m_score + m_op;
            m_mode = 0;
          end
        end
        default: begin
          if (m_score > m_high) m_high = m_score;
          m_mode = 0;
        end
      endcase
      m_pend = (old_mode == 2) ? 1'b0 : (m_pend | game_over);
      if (award_valid) begin
        if (old_n < int'(QDEPTH)) q.push_back(clamp_pts(award_pts));
        else m_drop = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("score_bcd", 64'(score_bcd), 64'(to_bcd(m_score)));
      chk("high_bcd", 64'(high_bcd), 64'(to_bcd(m_high)));
      chk("award_ready", 64'(award_ready), 64'(q.size() < int'(QDEPTH)));
      chk("busy", 64'(busy), 64'(m_mode != 0 || q.size() != 0 || m_pend));
      chk("saturated", 64'(saturated), 64'(m_sat));
      chk("dropped", 64'(dropped), 64'(m_drop));
      chk("hex", 64'(hex), 64'(model_hex(show_high ? m_high : m_score)));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] pts);
    bit acc = 1'b0;
    award_valid = 1'b1;
    award_pts   = pts;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = award_ready;
      tick();
    end
    award_valid = 1'b0;
    if (!acc) chk("send_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) tick();
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1; tick(); new_game = 1'b0;
  endtask

  int accepted;

  initial begin
    reset = 1'b1; award_valid = 1'b0; award_pts = '0;
    new_game = 1'b0; game_over = 1'b0; show_high = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("reset_score", 64'(score_bcd), 64'h0);
    chk("reset_hex", 64'(hex), 64'h0FFF_FFC0);

    // Single award: score appears exactly five edges after the accept.
    send(8'h05);
    repeat (4) tick();
    chk("latency_before", 64'(score_bcd), 64'h0);
    tick();
    chk("latency_at", 64'(score_bcd), 64'h0005);
    chk("busy_fall", 64'(busy), 64'd0);

    // Carry ripple.
    pulse_new_game();
    for (int i = 0; i < 10; i++) send(8'h99);
    send(8'h05);
    wait_idle();
    chk("score_0995", 64'(score_bcd), 64'h0995);
    send(8'h07);
    wait_idle();
    chk("score_1002", 64'(score_bcd), 64'h1002);

    // Saturation: 99*100 + 90 = 9990, then +15 clamps.
    pulse_new_game();
    for (int i = 0; i < 100; i++) send(8'h99);
    send(8'h90);
    wait_idle();
    chk("score_9990", 64'(score_bcd), 64'h9990);
    chk("sat_clear", 64'(saturated), 64'd0);
    send(8'h15);
    wait_idle();
    chk("score_9999", 64'(score_bcd), 64'h9999);
    chk("sat_set", 64'(saturated), 64'd1);
    send(8'h00);
    wait_idle();
    chk("score_sat_hold", 64'(score_bcd), 64'h9999);

    // FIFO overflow: six-cycle burst of 0x01.
    pulse_new_game();
    accepted = 0;
    award_valid = 1'b1; award_pts = 8'h01;
    for (int i = 0; i < 6; i++) begin
      if (award_ready) accepted++;
      tick();
    end
    award_valid = 1'b0;
    wait_idle();
    chk("ovf_dropped", 64'(dropped), 64'd1);
    chk("ovf_some_lost", 64'(accepted < 6), 64'd1);
    chk("ovf_score", 64'(score_bcd), 64'(to_bcd(accepted)));

    // Game-over waits for the queued awards.
    pulse_new_game();
    send(8'h10); send(8'h10); send(8'h10);
    game_over = 1'b1; tick(); game_over = 1'b0;
    chk("go_not_early", 64'(high_bcd), 64'h0);
    wait_idle();
    chk("high_0030", 64'(high_bcd), 64'h0030);
    pulse_new_game();
    send(8'h05);
    game_over = 1'b1; tick(); game_over = 1'b0;
    wait_idle();
    chk("high_kept", 64'(high_bcd), 64'h0030);

    // new_game aborts an add in flight.
    pulse_new_game();
    send(8'h50); send(8'h50); send(8'h50);
    tick();
    pulse_new_game();
    repeat (8) tick();
    chk("abort_score", 64'(score_bcd), 64'h0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_high", 64'(high_bcd), 64'h0030);

    // Display with leading-zero blanking.
    send(8'h40);
    wait_idle();
    chk("hex_0040", 64'(hex), 64'({7'h7F, 7'h7F, 7'b0011001, 7'b1000000}));
    show_high = 1'b1;
    #1;
    chk("hex_high", 64'(hex), 64'({7'h7F, 7'h7F, 7'b0110000, 7'b1000000}));
    show_high = 1'b0;

    // Invalid award digit clamps to 9.
    pulse_new_game();
    send(8'hF3);
    wait_idle();
    chk("clamp_93", 64'(score_bcd), 64'h0093);

    // Randomized soak.
    for (int i = 0; i < 4000; i++) begin
      award_valid = 1'($urandom_range(0, 1));
      award_pts   = 8'($urandom);
      game_over   = ($urandom_range(0, 24) == 0);
      new_game    = ($urandom_range(0, 299) == 0);
      show_high   = 1'($urandom_range(0, 1));
      tick();
    end
    award_valid = 1'b0; game_over = 1'b0; new_game = 1'b0;
    wait_idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
